// File: rtl/bram_fill_writer.sv
// bram_fill_writer: fills a contiguous window of a dual-port BRAM with an arithmetic
// sequence SEED + k*STEP, two words per clock (port A even offsets, port B odd offsets).
// Latency: first write is visible one cycle after start; done follows the last write by one cycle.
// Backpressure: none by default; with BRAM_FILL_HOLD_EN defined, hold=1 pauses the sequence in WRITE.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   start           one-cycle request pulse, accepted in IDLE or DONE, ignored in WRITE
//   hold            (only with BRAM_FILL_HOLD_EN) freezes the write sequence while high
//   addr_a/data_a/we_a, addr_b/data_b/we_b   RAM write ports
//   busy            high while the window is being written
//   done, error     completion / window-overflow flags, sticky until the next accepted start
//   display_value   last word written, sized to 16 bits
//
// Optional feature macro: BRAM_FILL_HOLD_EN (adds the hold input).

module bram_fill_writer #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 16,
  parameter int                BASE_ADDR = 0,
  parameter int                LEN       = 16,
  parameter logic [DATA_W-1:0] SEED      = 'h0001,
  parameter logic [DATA_W-1:0] STEP      = 'h0003
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef BRAM_FILL_HOLD_EN
  input  logic              hold,
`endif
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              we_b,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       display_value
);

  // Remaining-word counter must represent LEN = 2^ADDR_W, hence one extra bit.
  localparam int                CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LEN_C  = CNT_W'(LEN);
  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);
  // Each cycle advances both ports by two offsets, so the accumulators step by 2*STEP.
  localparam logic [DATA_W-1:0] STEP2  = {STEP[DATA_W-2:0], 1'b0};
  // Window that runs past the end of the RAM is rejected up front, before any write.
  localparam bit                OVF    =
    (longint'(BASE_ADDR) + longint'(LEN)) > (longint'(1) << ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;       // words still to write, counting the pair on the ports
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d; // port A data doubles as the even-offset accumulator
  logic                we_a_q, we_a_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d; // port B data doubles as the odd-offset accumulator
  logic                we_b_q, we_b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [15:0]         disp_q, disp_d;
  logic                hold_w;

`ifdef BRAM_FILL_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    we_a_d   = 1'b0;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;
    we_b_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    disp_d   = disp_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          disp_d  = 16'h0000;
          if (OVF) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            // Present offsets 0/1 immediately so the first write lands the cycle after start.
            state_d  = S_WRITE;
            busy_d   = 1'b1;
            rem_d    = LEN_C;
            addr_a_d = BASE_C;
            data_a_d = SEED;
            we_a_d   = 1'b1;
            if (LEN_C >= CNT_W'(2)) begin
              addr_b_d = BASE_C + ADDR_W'(1);
              data_b_d = SEED + STEP;
              we_b_d   = 1'b1;
            end
          end
        end
      end

      S_WRITE: begin
        if (rem_q <= CNT_W'(2)) begin
          // The pair on the ports this cycle was the final one. With one word left the
          // last offset sat on port A, otherwise on port B.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          disp_d  = (rem_q == CNT_W'(1)) ? 16'(data_a_q) : 16'(data_b_q);
        end else if (hold_w) begin
          // The presented pair has already been written; keep it on the ports, idle.
          we_a_d = 1'b0;
          we_b_d = 1'b0;
        end else begin
          rem_d    = rem_q - CNT_W'(2);
          addr_a_d = addr_a_q + ADDR_W'(2);
          data_a_d = data_a_q + STEP2;
          we_a_d   = 1'b1;
          // On an odd-length tail port B keeps its last address/data and stays disabled.
          if (rem_q >= CNT_W'(4)) begin
            addr_b_d = addr_b_q + ADDR_W'(2);
            data_b_d = data_b_q + STEP2;
            we_b_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      addr_a_q <= '0;
      data_a_q <= '0;
      we_a_q   <= 1'b0;
      addr_b_q <= '0;
      data_b_q <= '0;
      we_b_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      addr_a_q <= addr_a_d;
      data_a_q <= data_a_d;
      we_a_q   <= we_a_d;
      addr_b_q <= addr_b_d;
      data_b_q <= data_b_d;
      we_b_q   <= we_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      disp_q   <= disp_d;
    end
  end

  assign addr_a        = addr_a_q;
  assign data_a        = data_a_q;
  assign we_a          = we_a_q;
  assign addr_b        = addr_b_q;
  assign data_b        = data_b_q;
  assign we_b          = we_b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign display_value = disp_q;

endmodule

// File: tb/tb_bram_fill_writer.sv
// Bench for bram_fill_writer: four parameterisations run side by side against a
// word-level reference model (data = SEED + offset*STEP, written pairwise).
module tb_bram_fill_writer;

  localparam int N = 4;
  localparam int P_BASE [N] = '{0, 100, 1020, 0};
  localparam int P_LEN  [N] = '{16, 5, 8, 4};
  localparam int P_SEED [N] = '{1, 1, 1, 'hFFFF};
  localparam int P_STEP [N] = '{3, 3, 3, 1};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] start = '0;

  logic [9:0]  aa [N];
  logic [9:0]  ab [N];
  logic [15:0] da [N];
  logic [15:0] db [N];
  logic [15:0] dv [N];
  logic        wa [N];
  logic        wb [N];
  logic        bz [N];
  logic        dn [N];
  logic        er [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bram_fill_writer u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .addr_a(aa[0]), .data_a(da[0]), .we_a(wa[0]),
    .addr_b(ab[0]), .data_b(db[0]), .we_b(wb[0]),
    .busy(bz[0]), .done(dn[0]), .error(er[0]), .display_value(dv[0]));

  bram_fill_writer #(.BASE_ADDR(100), .LEN(5)) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .addr_a(aa[1]), .data_a(da[1]), .we_a(wa[1]),
    .addr_b(ab[1]), .data_b(db[1]), .we_b(wb[1]),
    .busy(bz[1]), .done(dn[1]), .error(er[1]), .display_value(dv[1]));

  bram_fill_writer #(.BASE_ADDR(1020), .LEN(8)) u2 (
    .clk(clk), .rst(rst), .start(start[2]),
    .addr_a(aa[2]), .data_a(da[2]), .we_a(wa[2]),
    .addr_b(ab[2]), .data_b(db[2]), .we_b(wb[2]),
    .busy(bz[2]), .done(dn[2]), .error(er[2]), .display_value(dv[2]));

  bram_fill_writer #(.LEN(4), .SEED(16'hFFFF), .STEP(16'h0001)) u3 (
    .clk(clk), .rst(rst), .start(start[3]),
    .addr_a(aa[3]), .data_a(da[3]), .we_a(wa[3]),
    .addr_b(ab[3]), .data_b(db[3]), .we_b(wb[3]),
    .busy(bz[3]), .done(dn[3]), .error(er[3]), .display_value(dv[3]));

  task automatic chk(input string nm, input int inst, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", nm, inst, $time, act, exp);
    end
  endtask

  function automatic int dat(int i, int off);
    return (P_SEED[i] + off * P_STEP[i]) & 'hFFFF;
  endfunction

  function automatic int adr(int i, int off);
    return (P_BASE[i] + off) % 1024;
  endfunction

  // Reference model: phase (0 idle, 1 writing, 2 done), current pair index j,
  // sticky flags and the last port-B word (held on an odd tail).
  int m_st   [N];
  int m_j    [N];
  int m_done [N];
  int m_err  [N];
  int m_disp [N];
  int m_lb_a [N];
  int m_lb_d [N];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        m_st[i] <= 0; m_j[i] <= 0; m_done[i] <= 0; m_err[i] <= 0;
        m_disp[i] <= 0; m_lb_a[i] <= 0; m_lb_d[i] <= 0;
      end else if (m_st[i] == 1) begin
        if (2 * m_j[i] + 2 >= P_LEN[i]) begin
          m_st[i]   <= 2;
          m_done[i] <= 1;
          m_disp[i] <= dat(i, P_LEN[i] - 1);
        end else begin
          m_j[i] <= m_j[i] + 1;
          if (2 * m_j[i] + 3 < P_LEN[i]) begin
            m_lb_a[i] <= adr(i, 2 * m_j[i] + 3);
            m_lb_d[i] <= dat(i, 2 * m_j[i] + 3);
          end
        end
      end else if (start[i]) begin
        m_disp[i] <= 0;
        if (P_BASE[i] + P_LEN[i] > 1024) begin
          m_st[i] <= 2; m_done[i] <= 1; m_err[i] <= 1;
        end else begin
          m_st[i] <= 1; m_j[i] <= 0; m_done[i] <= 0; m_err[i] <= 0;
          if (P_LEN[i] > 1) begin
            m_lb_a[i] <= adr(i, 1);
            m_lb_d[i] <= dat(i, 1);
          end
        end
      end
    end
  end

  // Every cycle, every instance: outputs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int j;
      int w;
      int ewb;
      j   = m_j[i];
      w   = (m_st[i] == 1) ? 1 : 0;
      ewb = (w == 1 && (2 * j + 1 < P_LEN[i])) ? 1 : 0;
      chk("busy", i, bz[i], w);
      chk("we_a", i, wa[i], w);
      chk("we_b", i, wb[i], ewb);
      chk("done", i, dn[i], m_done[i]);
      chk("error", i, er[i], m_err[i]);
      chk("display_value", i, dv[i], m_disp[i]);
      if (w == 1) begin
        chk("addr_a", i, aa[i], adr(i, 2 * j));
        chk("data_a", i, da[i], dat(i, 2 * j));
        if (ewb == 1) begin
          chk("addr_b", i, ab[i], adr(i, 2 * j + 1));
          chk("data_b", i, db[i], dat(i, 2 * j + 1));
          chk("ports_distinct", i, (aa[i] != ab[i]) ? 1 : 0, 1);
        end else begin
          chk("addr_b_held", i, ab[i], m_lb_a[i]);
          chk("data_b_held", i, db[i], m_lb_d[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt;
    #12;
    chk("rst_busy", 0, bz[0], 0);
    chk("rst_done", 0, dn[0], 0);
    chk("rst_we_a", 0, wa[0], 0);
    chk("rst_disp", 0, dv[0], 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Defaults, short odd window, overflowing window, wrapping data: all at once.
    start = '1;
    tick();
    start = '0;
    chk("s1_c0_addr_a", 0, aa[0], 0);
    chk("s1_c0_data_a", 0, da[0], 'h0001);
    chk("s1_c0_addr_b", 0, ab[0], 1);
    chk("s1_c0_data_b", 0, db[0], 'h0004);
    chk("s3_done", 2, dn[2], 1);
    chk("s3_error", 2, er[2], 1);
    chk("s3_we_a", 2, wa[2], 0);
    chk("s3_disp", 2, dv[2], 0);
    chk("s4_c0_data_a", 3, da[3], 'hFFFF);
    chk("s4_c0_data_b", 3, db[3], 'h0000);
    tick();
    chk("s4_c1_data_a", 3, da[3], 'h0001);
    chk("s4_c1_data_b", 3, db[3], 'h0002);
    tick();
    chk("s2_c2_we_b", 1, wb[1], 0);
    chk("s2_c2_addr_a", 1, aa[1], 104);
    chk("s2_c2_data_a", 1, da[1], 'h000D);
    chk("s4_disp", 3, dv[3], 'h0002);
    repeat (5) tick();
    chk("s1_c7_addr_a", 0, aa[0], 14);
    chk("s1_c7_data_a", 0, da[0], 'h002B);
    chk("s1_c7_data_b", 0, db[0], 'h002E);
    tick();
    chk("s1_done", 0, dn[0], 1);
    chk("s1_error", 0, er[0], 0);
    chk("s1_busy", 0, bz[0], 0);
    chk("s1_disp", 0, dv[0], 'h002E);
    chk("s2_disp", 1, dv[1], 'h000D);

    // Start during write cycle 3 is ignored.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (wa[0]) cnt++;
      if (k == 3) start[0] = 1'b1;
      if (k == 4) start[0] = 1'b0;
      tick();
    end
    chk("s5_write_cycles", 0, cnt, 8);
    chk("s5_disp", 0, dv[0], 'h002E);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("s5_restart_done", 0, dn[0], 0);
    chk("s5_restart_busy", 0, bz[0], 1);
    repeat (8) tick();
    chk("s5_rerun_done", 0, dn[0], 1);

    // Reset in write cycle 4, then a clean rerun.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("s6_we_a", 0, wa[0], 0);
    chk("s6_we_b", 0, wb[0], 0);
    chk("s6_busy", 0, bz[0], 0);
    chk("s6_done", 0, dn[0], 0);
    tick();
    rst = 1'b1;
    tick();
    chk("s6_idle_busy", 0, bz[0], 0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (8) tick();
    chk("s6_done_after", 0, dn[0], 1);
    chk("s6_disp_after", 0, dv[0], 'h002E);

    // Randomised starts with occasional resets.
    repeat (600) begin
      for (int i = 0; i < N; i++) start[i] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end
    start = '0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
